// File: rtl/pio_tunnel_pkg.sv
// Shared definitions for the BAR2 TLP tunnel: FIFO word layout,
// TX inject FSM states and the TLP header fields it inspects.
package pio_tunnel_pkg;

    localparam int DATA_MSB  = 63;
    localparam int VALID_BIT = 64;
    localparam int LAST_BIT  = 65;
    localparam int EN0_BIT   = 66;
    localparam int EN1_BIT   = 67;
    localparam int TAG_MSB   = 71;
    localparam int TAG_LSB   = 68;

    localparam int FMT0_BIT  = 29;
    localparam int TYPE_MSB  = 28;
    localparam int TYPE_LSB  = 24;

    localparam logic [3:0] MEM_TYPE_HI = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR1 = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } tx_beat_t;

    // MRd/MRdLk/MWr all share type[4:1] == 0
    function automatic logic is_mem_type(input logic [4:0] tlp_type);
        return tlp_type[4:1] == MEM_TYPE_HI;
    endfunction

endpackage

// File: rtl/pio_tx_sat_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module pio_tx_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pio_tx_inject.sv
// Tunnel RX FIFO -> PCIe AXIS TX injector with address/requester-ID rewrite.
// Define TX_INJECT_MEMONLY_EN to drop non-memory TLPs instead of forwarding them.
module pio_tx_inject
    import pio_tunnel_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic [71:0]      dout,
    input  logic             empty,
    output logic             rd_en,
    output logic [63:0]      s_axis_tx_tdata,
    output logic [7:0]       s_axis_tx_tkeep,
    output logic             s_axis_tx_tlast,
    output logic             s_axis_tx_tvalid,
    input  logic             s_axis_tx_tready,
    output logic [3:0]       s_axis_tx_tuser,
    input  logic [15:0]      cfg_completer_id,
    input  logic [31:0]      local_base,
    output logic [CNT_W-1:0] tlp_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    tx_state_e   state_q, state_d;
    tx_beat_t    beat_q, beat_d;
    logic        tvalid_q, tvalid_d;
    logic        mem_q, mem_d;
    logic        fmt4_q, fmt4_d;

    logic        w_valid;
    logic        w_last;
    logic        hdr_mem;
    logic        load;
    logic        tlp_inc;
    logic        drop_inc;
    logic [63:0] data_n;
    logic [7:0]  keep_n;
    logic        unused_ok;

    assign w_valid   = dout[VALID_BIT];
    assign w_last    = dout[LAST_BIT];
    assign keep_n    = {{4{dout[EN1_BIT]}}, {4{dout[EN0_BIT]}}};
    assign hdr_mem   = is_mem_type(dout[TYPE_MSB:TYPE_LSB]);
    assign unused_ok = ^{dout[TAG_MSB:TAG_LSB], local_base[19:0]};

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        tvalid_d = tvalid_q;
        mem_d    = mem_q;
        fmt4_d   = fmt4_q;
        rd_en    = 1'b0;
        load     = 1'b0;
        drop_inc = 1'b0;
        data_n   = dout[DATA_MSB:0];
        tlp_inc  = tvalid_q && s_axis_tx_tready && beat_q.last;

        if (tvalid_q && s_axis_tx_tready) begin
            tvalid_d = 1'b0;
        end

        // Dropping never needs the output slot, so it ignores backpressure
        if (state_q == DROP) begin
            rd_en = !empty;
        end else begin
            rd_en = !empty && (!tvalid_q || s_axis_tx_tready);
        end

        if (rd_en && w_valid) begin
            unique case (state_q)
                IDLE: begin
                    mem_d   = hdr_mem;
                    fmt4_d  = dout[FMT0_BIT];
                    load    = 1'b1;
                    state_d = w_last ? IDLE : HDR1;
                    if (hdr_mem) begin
                        data_n = {cfg_completer_id, dout[47:0]};
                    end
`ifdef TX_INJECT_MEMONLY_EN
                    if (!hdr_mem) begin
                        load     = 1'b0;
                        drop_inc = w_last;
                        state_d  = w_last ? IDLE : DROP;
                    end
`endif
                end
                HDR1: begin
                    load    = 1'b1;
                    state_d = w_last ? IDLE : DATA;
                    if (mem_q && fmt4_q) begin
                        data_n = {local_base[31:20], dout[51:32], 32'h0};
                    end else if (mem_q) begin
                        data_n = {dout[63:32], local_base[31:20], dout[19:0]};
                    end
                end
                DATA: begin
                    load    = 1'b1;
                    state_d = w_last ? IDLE : DATA;
                end
                DROP: begin
                    drop_inc = w_last;
                    state_d  = w_last ? IDLE : DROP;
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            beat_d   = '{data: data_n, keep: keep_n, last: w_last};
            tvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            tvalid_q <= 1'b0;
            mem_q    <= 1'b0;
            fmt4_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            tvalid_q <= tvalid_d;
            mem_q    <= mem_d;
            fmt4_q   <= fmt4_d;
        end
    end

    assign s_axis_tx_tdata  = beat_q.data;
    assign s_axis_tx_tkeep  = beat_q.keep;
    assign s_axis_tx_tlast  = beat_q.last;
    assign s_axis_tx_tvalid = tvalid_q;
    assign s_axis_tx_tuser  = 4'b0000;

    pio_tx_sat_cnt #(.CNT_W(CNT_W)) u_tlp_cnt (
        .clk (clk),
        .rst (sys_rst),
        .inc (tlp_inc),
        .clr (1'b0),
        .cnt (tlp_cnt)
    );

    pio_tx_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (sys_rst),
        .inc (drop_inc),
        .clr (1'b0),
        .cnt (drop_cnt)
    );

endmodule
